// File: rtl/vga_fb_wr_arbiter.sv
// Write-port arbiter for the VGA frame-buffer RAM: CPU word writes share the port with a constant-fill engine.
// Optional: define VGA_FILL_INC_EN to make fill data ramp as fill_pattern + word index.
module vga_fb_wr_arbiter #(
    parameter int WORDS       = 9600,
    parameter int AW          = 14,
    parameter int DW          = 32,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_data,
    output logic          cpu_gnt,
    output logic          cpu_oor,
    input  logic          fill_start,
    input  logic [AW-1:0] fill_base,
    input  logic [AW-1:0] fill_len,
    input  logic [DW-1:0] fill_pattern,
    output logic          fill_busy,
    output logic          fill_done,
    output logic [AW-1:0] wraddress,
    output logic [DW-1:0] data,
    output logic          wren
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [AW:0] WORDS_EXT = (AW+1)'(WORDS);
    localparam logic [3:0]  RUN_MAX   = 4'(MAX_CPU_RUN);

    state_t          state_r;
    state_t          state_next_s;
    logic [AW-1:0]   ptr_r;
    logic [AW:0]     end_r;
    logic [DW-1:0]   word_r;
    logic [3:0]      run_r;
    logic [AW-1:0]   wraddress_r;
    logic [DW-1:0]   data_r;
    logic            wren_r;
    logic            cpu_oor_r;

    logic            fill_req_s;
    logic            fill_done_s;
    logic            cpu_gnt_s;
    logic            cpu_win_s;
    logic            fill_win_s;
    logic            cpu_in_range_s;
    logic            fill_last_s;
    logic            start_valid_s;
    logic [AW:0]     fill_sum_s;
    logic [AW:0]     fill_end_s;

    // Start qualification and clipped end; AW+1 bits so base+len cannot wrap.
    always_comb begin
        start_valid_s  = (fill_len != {AW{1'b0}}) && ({1'b0, fill_base} < WORDS_EXT);
        fill_sum_s     = {1'b0, fill_base} + {1'b0, fill_len};
        if (fill_sum_s > WORDS_EXT) begin
            fill_end_s = WORDS_EXT;
        end else begin
            fill_end_s = fill_sum_s;
        end
        cpu_in_range_s = ({1'b0, cpu_addr} < WORDS_EXT);
        fill_last_s    = ({1'b0, ptr_r} == (end_r - (AW+1)'(1)));
    end

    // Fill FSM state register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fill FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fill_start) begin
                    if (start_valid_s) begin
                        state_next_s = ST_FILL;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (fill_win_s && fill_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Fill FSM outputs decoded from the state register.
    always_comb begin
        fill_req_s  = 1'b0;
        fill_done_s = 1'b0;
        case (state_r)
            ST_FILL: fill_req_s  = 1'b1;
            ST_DONE: fill_done_s = 1'b1;
            default: begin
                fill_req_s  = 1'b0;
                fill_done_s = 1'b0;
            end
        endcase
    end

    // CPU has priority until it has taken MAX_CPU_RUN slots in a row from a waiting fill.
    always_comb begin
        cpu_gnt_s = !(fill_req_s && (run_r == RUN_MAX));
        cpu_win_s = cpu_req && cpu_gnt_s;
        if (fill_req_s && !cpu_win_s) begin
            fill_win_s = 1'b1;
        end else begin
            fill_win_s = 1'b0;
        end
    end

    // Consecutive-CPU-grant counter while the fill is waiting.
    always_ff @(posedge clock) begin
        if (rst) begin
            run_r <= 4'd0;
        end else if (!fill_req_s) begin
            run_r <= 4'd0;
        end else if (fill_win_s) begin
            run_r <= 4'd0;
        end else if (cpu_win_s) begin
            run_r <= run_r + 4'd1;
        end else begin
            run_r <= run_r;
        end
    end

    // Fill pointer, end and data word; inputs are latched once so later changes are ignored.
    always_ff @(posedge clock) begin
        if (rst) begin
            ptr_r  <= '0;
            end_r  <= '0;
            word_r <= '0;
        end else if ((state_r == ST_IDLE) && fill_start && start_valid_s) begin
            ptr_r  <= fill_base;
            end_r  <= fill_end_s;
            word_r <= fill_pattern;
        end else if (fill_win_s) begin
            ptr_r  <= ptr_r + AW'(1);
`ifdef VGA_FILL_INC_EN
            word_r <= word_r + DW'(1);
`else
            word_r <= word_r;
`endif
        end else begin
            ptr_r  <= ptr_r;
            end_r  <= end_r;
            word_r <= word_r;
        end
    end

    // Registered RAM write port; out-of-range CPU writes are dropped and flagged.
    always_ff @(posedge clock) begin
        if (rst) begin
            wren_r      <= 1'b0;
            wraddress_r <= '0;
            data_r      <= '0;
            cpu_oor_r   <= 1'b0;
        end else begin
            wren_r    <= 1'b0;
            cpu_oor_r <= 1'b0;
            if (cpu_win_s) begin
                if (cpu_in_range_s) begin
                    wren_r      <= 1'b1;
                    wraddress_r <= cpu_addr;
                    data_r      <= cpu_data;
                end else begin
                    cpu_oor_r   <= 1'b1;
                end
            end else if (fill_win_s) begin
                wren_r      <= 1'b1;
                wraddress_r <= ptr_r;
                data_r      <= word_r;
            end else begin
                wraddress_r <= wraddress_r;
                data_r      <= data_r;
            end
        end
    end

    assign cpu_gnt   = cpu_gnt_s;
    assign cpu_oor   = cpu_oor_r;
    assign fill_busy = fill_req_s;
    assign fill_done = fill_done_s;
    assign wraddress = wraddress_r;
    assign data      = data_r;
    assign wren      = wren_r;

endmodule

// File: tb/tb_vga_fb_wr_arbiter.sv
// Directed self-checking bench for vga_fb_wr_arbiter (default parameters).
// Expected fill data follows VGA_FILL_INC_EN when the bench is built with that macro.
module tb_vga_fb_wr_arbiter;

    logic        clock = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_gnt;
    logic        cpu_oor;
    logic        fill_start;
    logic [13:0] fill_base;
    logic [13:0] fill_len;
    logic [31:0] fill_pattern;
    logic        fill_busy;
    logic        fill_done;
    logic [13:0] wraddress;
    logic [31:0] data;
    logic        wren;

    int vectors     = 0;
    int miscompares = 0;

    int          obs_wr;
    int          obs_busy;
    int          obs_done;
    int          obs_done_idx;
    int          obs_addr_err;
    logic [31:0] obs_data [0:3];

    int seq_err;
    int fills;
    int done_i;
    int done_n;

    always #5 clock = ~clock;

    vga_fb_wr_arbiter dut (
        .clock        (clock),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .cpu_gnt      (cpu_gnt),
        .cpu_oor      (cpu_oor),
        .fill_start   (fill_start),
        .fill_base    (fill_base),
        .fill_len     (fill_len),
        .fill_pattern (fill_pattern),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .wraddress    (wraddress),
        .data         (data),
        .wren         (wren)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] fill_word(input logic [31:0] pat, input int k);
        logic [31:0] inc;
        inc = 32'(k);
`ifndef VGA_FILL_INC_EN
        inc = 32'd0;
`endif
        return pat + inc;
    endfunction

    // Watches n cycles after a start cycle; index i is cycle start+1+i.
    task automatic observe(input int n, input logic [13:0] first, input int inject_idx);
        logic [13:0] ea;
        obs_wr = 0; obs_busy = 0; obs_done = 0; obs_done_idx = -1; obs_addr_err = 0;
        for (int j = 0; j < 4; j++) obs_data[j] = 32'd0;
        for (int i = 0; i < n; i++) begin
            cyc();
            fill_start = 1'b0;
            if (i == inject_idx) begin
                fill_start   = 1'b1;
                fill_base    = 14'd500;
                fill_len     = 14'd2;
                fill_pattern = 32'hFFFF_0000;
            end
            if (wren) begin
                ea = first + 14'(obs_wr);
                if (wraddress !== ea) obs_addr_err++;
                if (obs_wr < 4) obs_data[obs_wr] = data;
                obs_wr++;
            end
            if (fill_busy) obs_busy++;
            if (fill_done) begin
                obs_done++;
                obs_done_idx = i;
            end
        end
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_addr = 14'd0; cpu_data = 32'd0;
        fill_start = 1'b0; fill_base = 14'd0; fill_len = 14'd0; fill_pattern = 32'd0;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_wraddress", 32'(wraddress), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_cpu_oor", 32'(cpu_oor), 32'd0);
        chk("rst_fill_busy", 32'(fill_busy), 32'd0);
        chk("rst_fill_done", 32'(fill_done), 32'd0);
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd1);
        cyc();
        chk("idle_wren", 32'(wren), 32'd0);
        chk("idle_gnt", 32'(cpu_gnt), 32'd1);

        // Single CPU write
        cpu_req = 1'b1; cpu_addr = 14'd5; cpu_data = 32'hDEAD_BEEF;
        #1;
        chk("cpu_gnt_idle", 32'(cpu_gnt), 32'd1);
        cyc();
        cpu_req = 1'b0;
        chk("cpu_wr_wren", 32'(wren), 32'd1);
        chk("cpu_wr_addr", 32'(wraddress), 32'd5);
        chk("cpu_wr_data", data, 32'hDEAD_BEEF);
        chk("cpu_wr_oor", 32'(cpu_oor), 32'd0);
        cyc();
        chk("post_wr_wren", 32'(wren), 32'd0);
        chk("hold_addr", 32'(wraddress), 32'd5);
        chk("hold_data", data, 32'hDEAD_BEEF);

        // Clear screen with no CPU traffic
        fill_base = 14'd0; fill_len = 14'd9600; fill_pattern = 32'd0; fill_start = 1'b1;
        observe(9605, 14'd0, -1);
        chk("clr_writes", 32'(obs_wr), 32'd9600);
        chk("clr_order", 32'(obs_addr_err), 32'd0);
        chk("clr_busy_cycles", 32'(obs_busy), 32'd9600);
        chk("clr_done_count", 32'(obs_done), 32'd1);
        chk("clr_done_at", 32'(obs_done_idx), 32'd9600);
        chk("clr_last_data", data, fill_word(32'd0, 9599));
        chk("clr_last_addr", 32'(wraddress), 32'd9599);

        // Contention: CPU requests every cycle, starting in the same cycle as the fill
        cpu_req = 1'b1; cpu_addr = 14'd200; cpu_data = 32'h1111_0000;
        fill_base = 14'd100; fill_len = 14'd10; fill_pattern = 32'hA5A5_A5A5; fill_start = 1'b1;
        #1;
        chk("cont_gnt_at_start", 32'(cpu_gnt), 32'd1);
        seq_err = 0; fills = 0; done_i = -1; done_n = 0;
        for (int i = 0; i < 52; i++) begin
            cyc();
            fill_start = 1'b0;
            if (i >= 5 && (i % 5) == 0) begin
                if (wren !== 1'b1 || wraddress !== 14'(100 + fills) || data !== fill_word(32'hA5A5_A5A5, fills))
                    seq_err++;
                fills++;
            end else if (i <= 50) begin
                if (wren !== 1'b1 || wraddress !== 14'd200 || data !== 32'h1111_0000) seq_err++;
            end else begin
                if (wren !== 1'b0) seq_err++;
            end
            if (fill_done) begin
                done_i = i;
                done_n++;
            end
            #1;
            if (cpu_gnt !== ((i >= 4 && i <= 49 && (i % 5) == 4) ? 1'b0 : 1'b1)) seq_err++;
            if (i == 50) cpu_req = 1'b0;
        end
        chk("cont_sequence", 32'(seq_err), 32'd0);
        chk("cont_fill_writes", 32'(fills), 32'd10);
        chk("cont_done_at", 32'(done_i), 32'd50);
        chk("cont_done_count", 32'(done_n), 32'd1);
        chk("cont_busy_after", 32'(fill_busy), 32'd0);

        // Clipped fill at the top of the buffer
        fill_base = 14'd9598; fill_len = 14'd5; fill_pattern = 32'h0000_00C3; fill_start = 1'b1;
        observe(6, 14'd9598, -1);
        chk("clip_writes", 32'(obs_wr), 32'd2);
        chk("clip_order", 32'(obs_addr_err), 32'd0);
        chk("clip_busy", 32'(obs_busy), 32'd2);
        chk("clip_done_count", 32'(obs_done), 32'd1);
        chk("clip_done_at", 32'(obs_done_idx), 32'd2);
        chk("clip_data1", obs_data[1], fill_word(32'h0000_00C3, 1));

        // Zero length: done in the cycle after the start cycle, no writes
        fill_base = 14'd20; fill_len = 14'd0; fill_pattern = 32'h0000_0001; fill_start = 1'b1;
        observe(4, 14'd20, -1);
        chk("len0_writes", 32'(obs_wr), 32'd0);
        chk("len0_busy", 32'(obs_busy), 32'd0);
        chk("len0_done_count", 32'(obs_done), 32'd1);
        chk("len0_done_at", 32'(obs_done_idx), 32'd0);

        // Base past the end: same as zero length
        fill_base = 14'd9600; fill_len = 14'd4; fill_pattern = 32'h0000_0002; fill_start = 1'b1;
        observe(4, 14'd9600, -1);
        chk("base_oor_writes", 32'(obs_wr), 32'd0);
        chk("base_oor_done_count", 32'(obs_done), 32'd1);
        chk("base_oor_done_at", 32'(obs_done_idx), 32'd0);

        // Out-of-range CPU write is granted but dropped
        cpu_req = 1'b1; cpu_addr = 14'd9600; cpu_data = 32'h1234_5678;
        #1;
        chk("oor_gnt", 32'(cpu_gnt), 32'd1);
        cyc();
        cpu_req = 1'b0;
        chk("oor_wren", 32'(wren), 32'd0);
        chk("oor_flag", 32'(cpu_oor), 32'd1);
        chk("oor_addr_hold", 32'(wraddress), 32'd9599);
        chk("oor_data_hold", data, fill_word(32'h0000_00C3, 1));
        cyc();
        chk("oor_flag_clear", 32'(cpu_oor), 32'd0);

        // Restart and input changes during a fill are ignored
        fill_base = 14'd10; fill_len = 14'd3; fill_pattern = 32'h0000_0055; fill_start = 1'b1;
        observe(8, 14'd10, 1);
        chk("restart_writes", 32'(obs_wr), 32'd3);
        chk("restart_order", 32'(obs_addr_err), 32'd0);
        chk("restart_done_count", 32'(obs_done), 32'd1);
        chk("restart_done_at", 32'(obs_done_idx), 32'd3);
        chk("restart_data2", obs_data[2], fill_word(32'h0000_0055, 2));

        // Reset mid-fill: busy drops, no done pulse, nothing more written
        fill_base = 14'd0; fill_len = 14'd50; fill_pattern = 32'h0000_0077; fill_start = 1'b1;
        observe(5, 14'd0, -1);
        chk("pre_rst_writes", 32'(obs_wr), 32'd4);
        chk("pre_rst_busy", 32'(obs_busy), 32'd5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_mid_busy", 32'(fill_busy), 32'd0);
        chk("rst_mid_wren", 32'(wren), 32'd0);
        chk("rst_mid_done", 32'(fill_done), 32'd0);
        observe(60, 14'd0, -1);
        chk("post_rst_writes", 32'(obs_wr), 32'd0);
        chk("post_rst_done", 32'(obs_done), 32'd0);
        chk("post_rst_busy", 32'(obs_busy), 32'd0);

        // Pattern wrap; ramps through zero when VGA_FILL_INC_EN is defined
        fill_base = 14'd0; fill_len = 14'd3; fill_pattern = 32'hFFFF_FFFE; fill_start = 1'b1;
        observe(6, 14'd0, -1);
        chk("ramp_writes", 32'(obs_wr), 32'd3);
        chk("ramp_data0", obs_data[0], fill_word(32'hFFFF_FFFE, 0));
        chk("ramp_data1", obs_data[1], fill_word(32'hFFFF_FFFE, 1));
        chk("ramp_data2", obs_data[2], fill_word(32'hFFFF_FFFE, 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
